// File: rtl/axil_arbiter_wr_pkg.sv
// Shared types and helpers for the AXI-Lite write arbiter: FSM states, index widths, slave decode.
// Pure declarations; no latency and no flow control of its own.
package axil_ic_pkg;

  localparam int NUM_MST_DEF = 3;
  localparam int NUM_SLV_DEF = 4;
  localparam int ADDR_W_DEF  = 8;

  localparam int MST_IDX_W = $clog2(NUM_MST_DEF);
  localparam int SLV_IDX_W = $clog2(NUM_SLV_DEF);

  typedef enum logic {IDLE, BUSY} arb_state_t;

  typedef struct packed {
    logic                 vld;
    logic [SLV_IDX_W-1:0] idx;
  } slv_dec_t;

  // Target slave comes from the top address bits; indices past the last slave are unmapped.
  function automatic slv_dec_t slave_decode(input logic [ADDR_W_DEF-1:0] addr);
    slv_dec_t r;
    r.idx = addr[ADDR_W_DEF-1 -: SLV_IDX_W];
    r.vld = ({1'b0, r.idx} < (SLV_IDX_W+1)'(NUM_SLV_DEF));
    return r;
  endfunction

endpackage

// File: rtl/axil_arbiter_wr_if.sv
// Request/observe/grant bundle between the write crossbar side and the write arbiter.
// Grants are registered in the arbiter; the bundle itself adds no latency and no backpressure.
interface axil_arbiter_wr_if #(
  parameter int NUMBER_MASTER  = axil_ic_pkg::NUM_MST_DEF,
  parameter int NUMBER_SLAVE   = axil_ic_pkg::NUM_SLV_DEF,
  parameter int AXI_ADDR_WIDTH = axil_ic_pkg::ADDR_W_DEF
) ();
  localparam int MW = $clog2(NUMBER_MASTER);
  localparam int SW = $clog2(NUMBER_SLAVE);

  logic [AXI_ADDR_WIDTH-1:0] m_axil_awaddr [NUMBER_MASTER];
  logic [NUMBER_MASTER-1:0]  m_axil_awvalid;
  logic [NUMBER_SLAVE-1:0]   s_axil_bvalid;
  logic [NUMBER_SLAVE-1:0]   s_axil_bready;

  logic [NUMBER_MASTER-1:0]  grant_wr           [NUMBER_SLAVE];
  logic [NUMBER_SLAVE-1:0]   grant_wr_trans     [NUMBER_MASTER];
  logic [MW-1:0]             grant_wr_cdr       [NUMBER_SLAVE];
  logic [SW-1:0]             grant_wr_cdr_trans [NUMBER_MASTER];

  modport slave (
    input  m_axil_awaddr, m_axil_awvalid, s_axil_bvalid, s_axil_bready,
    output grant_wr, grant_wr_trans, grant_wr_cdr, grant_wr_cdr_trans
  );

  modport master (
    output m_axil_awaddr, m_axil_awvalid, s_axil_bvalid, s_axil_bready,
    input  grant_wr, grant_wr_trans, grant_wr_cdr, grant_wr_cdr_trans
  );
endinterface

// File: rtl/axil_rr_arbiter.sv
// Single-slave grant FSM: round-robin (or fixed priority with AXIL_ARB_WR_FIXED_PRIO_EN), 1-cycle grant latency.
// Grant holds until the slave's B handshake; new requests are ignored while BUSY.
module axil_rr_arbiter
  import axil_ic_pkg::*;
#(
  parameter int NM = NUM_MST_DEF,
  parameter int MW = $clog2(NM)
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic [NM-1:0] req_i,
  input  logic          done_i,
  output logic [NM-1:0] grant_o,
  output logic [NM-1:0] grant_nxt_o,
  output logic [MW-1:0] grant_cdr_o
);

  arb_state_t    state_q, state_d;
  logic [NM-1:0] grant_q, grant_d;
  logic [MW-1:0] cdr_q, cdr_d;
  logic [MW-1:0] win;

`ifdef AXIL_ARB_WR_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int k = NM - 1; k >= 0; k--) begin
      if (req_i[k]) win = MW'(k);
    end
  end
`else
  logic [MW-1:0] last_q, last_d;

  // Search starts one past the previous winner and wraps.
  always_comb begin
    logic found;
    int   idx;
    win   = '0;
    found = 1'b0;
    for (int k = 1; k <= NM; k++) begin
      idx = (int'(last_q) + k) % NM;
      if (!found && req_i[idx]) begin
        found = 1'b1;
        win   = MW'(idx);
      end
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    cdr_d   = cdr_q;
`ifndef AXIL_ARB_WR_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (|req_i) begin
          state_d = BUSY;
          grant_d = NM'(1) << win;
          cdr_d   = win;
`ifndef AXIL_ARB_WR_FIXED_PRIO_EN
          last_d  = win;
`endif
        end
      end
      BUSY: begin
        if (done_i) begin
          state_d = IDLE;
          grant_d = '0;
          cdr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      cdr_q   <= '0;
`ifndef AXIL_ARB_WR_FIXED_PRIO_EN
      last_q  <= MW'(NM - 1);
`endif
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      cdr_q   <= cdr_d;
`ifndef AXIL_ARB_WR_FIXED_PRIO_EN
      last_q  <= last_d;
`endif
    end
  end

  assign grant_o     = grant_q;
  assign grant_nxt_o = grant_d;
  assign grant_cdr_o = cdr_q;

endmodule

// File: rtl/axil_arbiter_wr.sv
// AXI-Lite write arbiter: AW decode, one arbiter per slave (AXIL_ARB_WR_FIXED_PRIO_EN selects fixed priority), 1-cycle grant.
// A master holding any grant is masked from all arbiters; grants release one cycle after the B handshake.
module axil_arbiter_wr
  import axil_ic_pkg::*;
#(
  parameter int NUMBER_MASTER  = NUM_MST_DEF,
  parameter int NUMBER_SLAVE   = NUM_SLV_DEF,
  parameter int AXI_ADDR_WIDTH = ADDR_W_DEF
) (
  input  logic               aclk,
  input  logic               aresetn,
  axil_arbiter_wr_if.slave   bus
);

  localparam int MW = $clog2(NUMBER_MASTER);
  localparam int SW = $clog2(NUMBER_SLAVE);

  slv_dec_t                 dec       [NUMBER_MASTER];
  logic [NUMBER_MASTER-1:0] busy;
  logic [NUMBER_MASTER-1:0] req       [NUMBER_SLAVE];
  logic [NUMBER_MASTER-1:0] grant_nxt [NUMBER_SLAVE];
  logic [SW-1:0]            cdr_trans_d [NUMBER_MASTER];
  logic [SW-1:0]            cdr_trans_q [NUMBER_MASTER];

  always_comb begin
    for (int m = 0; m < NUMBER_MASTER; m++) begin
      dec[m]  = slave_decode(bus.m_axil_awaddr[m]);
      busy[m] = |bus.grant_wr_trans[m];
    end
    for (int s = 0; s < NUMBER_SLAVE; s++) begin
      for (int m = 0; m < NUMBER_MASTER; m++) begin
        req[s][m] = bus.m_axil_awvalid[m] & dec[m].vld &
                    (int'(dec[m].idx) == s) & ~busy[m];
      end
    end
  end

  for (genvar s = 0; s < NUMBER_SLAVE; s++) begin : g_arb
    axil_rr_arbiter #(
      .NM (NUMBER_MASTER),
      .MW (MW)
    ) u_arb (
      .clk_i       (aclk),
      .rst_ni      (aresetn),
      .req_i       (req[s]),
      .done_i      (bus.s_axil_bvalid[s] & bus.s_axil_bready[s]),
      .grant_o     (bus.grant_wr[s]),
      .grant_nxt_o (grant_nxt[s]),
      .grant_cdr_o (bus.grant_wr_cdr[s])
    );
  end

  always_comb begin
    for (int m = 0; m < NUMBER_MASTER; m++) begin
      for (int s = 0; s < NUMBER_SLAVE; s++) begin
        bus.grant_wr_trans[m][s] = bus.grant_wr[s][m];
      end
    end
  end

  // Per-master slave index is encoded from the arbiters' next state so it leaves a flop too.
  always_comb begin
    for (int m = 0; m < NUMBER_MASTER; m++) begin
      cdr_trans_d[m] = '0;
      for (int s = 0; s < NUMBER_SLAVE; s++) begin
        if (grant_nxt[s][m]) cdr_trans_d[m] = SW'(s);
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int m = 0; m < NUMBER_MASTER; m++) cdr_trans_q[m] <= '0;
    end else begin
      cdr_trans_q <= cdr_trans_d;
    end
  end

  always_comb begin
    for (int m = 0; m < NUMBER_MASTER; m++) bus.grant_wr_cdr_trans[m] = cdr_trans_q[m];
  end

endmodule

// File: tb/tb_axil_arbiter_wr.sv
// Bench for axil_arbiter_wr: directed scenarios plus random traffic against an ownership-table model.
// Build with AXIL_ARB_WR_FIXED_PRIO_EN to check the fixed-priority variant.
module tb_axil_arbiter_wr;

  localparam int NM = 3;
  localparam int NS = 4;
  localparam int AW = 8;
  localparam int SW = $clog2(NS);

  logic aclk;
  logic aresetn;

  axil_arbiter_wr_if #(.NUMBER_MASTER(NM), .NUMBER_SLAVE(NS), .AXI_ADDR_WIDTH(AW)) bus ();

  axil_arbiter_wr #(
    .NUMBER_MASTER  (NM),
    .NUMBER_SLAVE   (NS),
    .AXI_ADDR_WIDTH (AW)
  ) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .bus     (bus)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  int err_cnt = 0;
  int chk_cnt = 0;

  // owner[s] is the master currently holding slave s, -1 when free.
  int owner [NS];
  int last  [NS];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      owner[s] = -1;
      last[s]  = NM - 1;
    end
  endtask

  function automatic int target(input int m);
    return int'(bus.m_axil_awaddr[m]) >> (AW - SW);
  endfunction

  task automatic model_edge();
    bit busy [NM];
    int nown [NS];
    if (!aresetn) begin
      model_reset();
      return;
    end
    for (int m = 0; m < NM; m++) busy[m] = 1'b0;
    for (int s = 0; s < NS; s++) if (owner[s] >= 0) busy[owner[s]] = 1'b1;
    for (int s = 0; s < NS; s++) begin
      nown[s] = owner[s];
      if (owner[s] < 0) begin
        for (int k = 1; k <= NM; k++) begin
`ifdef AXIL_ARB_WR_FIXED_PRIO_EN
          int m = k - 1;
`else
          int m = (last[s] + k) % NM;
`endif
          if (nown[s] < 0 && bus.m_axil_awvalid[m] && target(m) == s && !busy[m]) begin
            nown[s] = m;
            last[s] = m;
          end
        end
      end else if (bus.s_axil_bvalid[s] && bus.s_axil_bready[s]) begin
        nown[s] = -1;
      end
    end
    for (int s = 0; s < NS; s++) owner[s] = nown[s];
  endtask

  task automatic check_all();
    for (int s = 0; s < NS; s++) begin
      chk($sformatf("gnt[%0d]", s), 32'(bus.grant_wr[s]), (owner[s] < 0) ? 0 : (1 << owner[s]));
      chk($sformatf("cdr[%0d]", s), 32'(bus.grant_wr_cdr[s]), (owner[s] < 0) ? 0 : owner[s]);
    end
    for (int m = 0; m < NM; m++) begin
      logic [31:0] et, ec;
      et = 0;
      ec = 0;
      for (int s = 0; s < NS; s++) begin
        if (owner[s] == m) begin
          et = et | (32'd1 << s);
          ec = s;
        end
      end
      chk($sformatf("trans[%0d]", m), 32'(bus.grant_wr_trans[m]), et);
      chk($sformatf("cdr_trans[%0d]", m), 32'(bus.grant_wr_cdr_trans[m]), ec);
    end
  endtask

  task automatic step();
    @(posedge aclk);
    model_edge();
    @(negedge aclk);
    check_all();
  endtask

  task automatic clear_inputs();
    for (int m = 0; m < NM; m++) bus.m_axil_awaddr[m] = '0;
    bus.m_axil_awvalid = '0;
    bus.s_axil_bvalid  = '0;
    bus.s_axil_bready  = '0;
  endtask

  int got [$];
  int exp_ord [4];
  int age;
  int idle;

  initial begin
`ifdef AXIL_ARB_WR_FIXED_PRIO_EN
    exp_ord = '{0, 0, 0, 0};
`else
    exp_ord = '{0, 1, 2, 0};
`endif
    clear_inputs();
    aresetn = 1'b0;
    model_reset();

    // Reset held with random requests: nothing may be granted.
    for (int c = 0; c < 4; c++) begin
      bus.m_axil_awvalid = NM'($urandom);
      for (int m = 0; m < NM; m++) bus.m_axil_awaddr[m] = AW'($urandom);
      step();
    end
    chk("rst_gnt0", 32'(bus.grant_wr[0]), 0);
    clear_inputs();
    aresetn = 1'b1;
    step();

    // Single write from M1 to slave 2.
    bus.m_axil_awaddr[1] = 8'h85;
    bus.m_axil_awvalid   = 3'b010;
    step();
    chk("single_gnt2", 32'(bus.grant_wr[2]), 32'b010);
    chk("single_cdr2", 32'(bus.grant_wr_cdr[2]), 1);
    chk("single_trans1", 32'(bus.grant_wr_trans[1]), 32'b0100);
    chk("single_cdrt1", 32'(bus.grant_wr_cdr_trans[1]), 2);
    bus.m_axil_awvalid = '0;
    step();
    chk("single_hold", 32'(bus.grant_wr[2]), 32'b010);
    bus.s_axil_bvalid[2] = 1'b1;
    bus.s_axil_bready[2] = 1'b1;
    step();
    chk("single_rel", 32'(bus.grant_wr[2]), 0);
    chk("single_rel_t", 32'(bus.grant_wr_trans[1]), 0);
    clear_inputs();
    step();

    // Contention on slave 0, B two cycles into each grant.
    for (int m = 0; m < NM; m++) bus.m_axil_awaddr[m] = 8'h10;
    bus.m_axil_awvalid = '1;
    age  = 0;
    idle = 0;
    for (int c = 0; c < 40 && got.size() < 4; c++) begin
      step();
      bus.s_axil_bvalid = '0;
      bus.s_axil_bready = '0;
      if (bus.grant_wr[0] != 0) begin
        if (age == 0) begin
          if (got.size() > 0) chk("cont_gap", idle, 1);
          got.push_back(int'(bus.grant_wr_cdr[0]));
          idle = 0;
        end
        age++;
        if (age == 2) begin
          bus.s_axil_bvalid[0] = 1'b1;
          bus.s_axil_bready[0] = 1'b1;
        end
      end else begin
        age = 0;
        if (got.size() > 0) idle++;
      end
    end
    chk("cont_count", got.size(), 4);
    for (int i = 0; i < got.size() && i < 4; i++) chk($sformatf("cont_ord[%0d]", i), got[i], exp_ord[i]);
    bus.m_axil_awvalid   = '0;
    bus.s_axil_bvalid[0] = 1'b1;
    bus.s_axil_bready[0] = 1'b1;
    step();
    clear_inputs();
    step();

    // Parallel grants on slaves 0 and 3.
    bus.m_axil_awaddr[0] = 8'h00;
    bus.m_axil_awaddr[2] = 8'hC0;
    bus.m_axil_awvalid   = 3'b101;
    step();
    chk("par_gnt0", 32'(bus.grant_wr[0]), 32'b001);
    chk("par_gnt3", 32'(bus.grant_wr[3]), 32'b100);

    // M0 keeps slave 0 and asks for slave 1: masked until its grant is gone.
    bus.m_axil_awaddr[0] = 8'h40;
    bus.m_axil_awvalid   = 3'b001;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("busy_gnt1", 32'(bus.grant_wr[1]), 0);
    end
    bus.s_axil_bvalid = 4'b0001;
    bus.s_axil_bready = 4'b0001;
    step();
    chk("busy_rel0", 32'(bus.grant_wr[0]), 0);
    chk("busy_gnt1_n1", 32'(bus.grant_wr[1]), 0);
    bus.s_axil_bvalid = '0;
    bus.s_axil_bready = '0;
    step();
    chk("busy_gnt1_n2", 32'(bus.grant_wr[1]), 32'b001);

    // Asynchronous reset while M0 holds slave 1 and M2 holds slave 3.
    aresetn = 1'b0;
    #1;
    chk("arst_gnt1", 32'(bus.grant_wr[1]), 0);
    chk("arst_gnt3", 32'(bus.grant_wr[3]), 0);
    chk("arst_trans0", 32'(bus.grant_wr_trans[0]), 0);
    chk("arst_cdrt2", 32'(bus.grant_wr_cdr_trans[2]), 0);
    model_reset();
    for (int c = 0; c < 3; c++) begin
      bus.m_axil_awvalid = NM'($urandom);
      step();
    end
    clear_inputs();
    aresetn = 1'b1;
    step();

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      for (int m = 0; m < NM; m++) begin
        bus.m_axil_awaddr[m]  = AW'($urandom);
        bus.m_axil_awvalid[m] = ($urandom_range(9) < 7);
      end
      for (int s = 0; s < NS; s++) begin
        bus.s_axil_bvalid[s] = ($urandom_range(2) == 0);
        bus.s_axil_bready[s] = ($urandom_range(1) == 0);
      end
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
